// File: rtl/glip_channel_arbiter.sv
// Round-robin arbiter sharing one downstream glip_channel among N upstream channels.
// Each grant costs one idle bubble and lasts up to MAX_BURST transfers.
module glip_channel_arbiter #(
    parameter int WIDTH     = 16,
    parameter int N         = 2,
    parameter int MAX_BURST = 8,
    localparam int IDX_W    = (N > 1) ? $clog2(N) : 1,
    localparam int CNT_W    = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               grant_valid,
    output logic [IDX_W-1:0]   grant_idx
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t             state, state_next;
    logic [IDX_W-1:0]   last_idx, last_next;
    logic [IDX_W-1:0]   grant_next;
    logic [CNT_W-1:0]   count, count_next;
    logic [IDX_W-1:0]   pick;
    logic               found;
    logic               xfer;

    // Scan last+1, last+2, ... (mod N) for the first requesting channel.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        found = 1'b0;
        pick  = '0;
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (int'(last_idx) + k) % N;
            if (!found && in_valid[c]) begin
                found = 1'b1;
                pick  = IDX_W'(c);
            end
        end
    end

    always_comb begin
        out_data  = in_data[int'(grant_idx)*WIDTH +: WIDTH];
        out_valid = 1'b0;
        in_ready  = '0;
        if (state == GRANT) begin
            out_valid           = in_valid[grant_idx];
            in_ready[grant_idx] = out_ready;
        end
    end

    assign grant_valid = (state == GRANT);
    assign xfer        = (state == GRANT) && in_valid[grant_idx] && out_ready;

    always_comb begin
        state_next = state;
        grant_next = grant_idx;
        last_next  = last_idx;
        count_next = count;
        case (state)
            IDLE: begin
                if (found) begin
                    state_next = GRANT;
                    grant_next = pick;
                    last_next  = pick;
                    count_next = '0;
                end
            end
            GRANT: begin
                if (xfer) begin
                    count_next = count + CNT_W'(1);
                    if (count == CNT_W'(MAX_BURST - 1)) begin
                        state_next = IDLE;
                    end
                end else if (!in_valid[grant_idx]) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (rst) begin
            state     <= IDLE;
            grant_idx <= '0;
            last_idx  <= IDX_W'(N - 1);
            count     <= '0;
        end else begin
            state     <= state_next;
            grant_idx <= grant_next;
            last_idx  <= last_next;
            count     <= count_next;
        end
    end

endmodule
